bias_loader: RTL and testbench
==============================

// Module: bias_loader
// PURPOSE
//  Host-side writer for the bias vector consumed by the bias-add stage of the layer pipeline.
//  - Accepts M bias words from a valid/ready stream sourced by the PS DMA.
//  - Assembles them in a shadow buffer.
//  - Atomically commits them to the active vector b[0:M-1][0:0] driven into the bias stage.
//  - Commits are blocked while the datapath is mid-inference, so b never changes under a running vector.
// PARAMETERS
//  M       5   rows in the bias vector; must match the bias stage M
//  DATA_W  16  word width; from shared package, equals $bits(data_type)
// PORTS
//  clk          in   1        rising-edge clock, single domain
//  reset        in   1        asynchronous, active-high; clears all state
//  s_data       in   DATA_W   stream word (data_type, two's complement)
//  s_valid      in   1        s_data valid
//  s_last       in   1        marks final word of a load frame
//  s_ready      out  1        loader can accept a word
//  hold         in   1        datapath busy; high blocks commit
//  b            out  M x DATA_W  active bias vector, data_type b[0:M-1][0:0]
//  b_valid      out  1        active vector holds a committed load
//  commit       out  1        1-cycle pulse on the cycle b updates
//  err_len      out  1        1-cycle pulse: frame length wrong, frame discarded
//  err_csum     out  1        1-cycle pulse: checksum mismatch (macro only, else tied 0)
// BEHAVIOUR
//  - Reset: asynchronous, active-high. While reset is high, all outputs are 0:
//    b[*], b_valid, s_ready, commit, err_*. Internal state clears: state=FILL, idx=0, shadow=0.
//    s_ready rises on the first clock edge after reset deasserts.
//  - Handshake: a word transfers on a cycle with s_valid && s_ready.
//    s_data and s_last are sampled only on a transfer. s_valid may be held off arbitrarily.
//  - FSM states: FILL, COMMIT, DROP.
//  - FILL, s_ready=1:
//    - Each transfer writes shadow[idx] and increments idx.
//    - Transfer with idx==M-1 and s_last=1 -> COMMIT.
//    - Transfer with s_last=1 and idx<M-1 -> err_len pulse, idx=0, stay in FILL; b untouched.
//    - Transfer with idx==M-1 and s_last=0 -> err_len pulse -> DROP.
//  - DROP, s_ready=1: discard words until a transfer with s_last=1, then idx=0 -> FILL.
//  - COMMIT, s_ready=0:
//    - If hold=0: b<=shadow, b_valid<=1, commit pulses, idx=0 -> FILL.
//    - If hold=1: wait with shadow intact; commit fires on the first cycle hold=0.
//  - Latency: last word accepted at edge N -> b updates at edge N+1 when hold=0,
//    otherwise at the first edge with hold=0.
//  - b is fully registered and changes only on commit; partial frames never reach b.
//  - b_valid is sticky after the first commit until reset.
//  - Reset asserted mid-frame or during a COMMIT wait: frame lost, b and b_valid cleared.
//  - idx never exceeds M-1; no wrap into a new frame without s_last.
// CONFIGURATION
//  - BIAS_LOADER_CHECKSUM_EN defined:
//    - The frame is M words plus 1 checksum word. s_last must be on the checksum word.
//    - The checksum equals the sum of the M words mod 2^DATA_W.
//    - A running sum is accumulated in FILL.
//    - Checksum transfer with s_last=1: a mismatch pulses err_csum, discards the frame and returns
//      to FILL; a match goes to COMMIT.
//    - s_last on any of the M data words pulses err_len, discards the frame and returns to FILL.
//      If this happens on word M-1, err_len is raised in FILL, not DROP.
//    - Checksum word with s_last=0 -> err_len, DROP.
//  - BIAS_LOADER_CHECKSUM_EN undefined: frame is exactly M words; err_csum tied 0; no adder.
// STRUCTURE
//  - Shared package nn_pkg: DATA_W, data_type (logic signed [DATA_W-1:0]), loader state enum.
//    The bias stage also uses nn_pkg.
//  - No sub-module. Shadow and active arrays are generate-loop registers with a single FSM.
//    The checksum accumulator is inline under `ifdef.
// TESTING (M=5, DATA_W=16)
//  1. Basic load:
//     stream 1,2,3,4,5 with s_last on 5, hold=0 -> commit 1 cycle after the 5th transfer;
//     b={1,2,3,4,5}; b_valid=1.
//  2. Short frame:
//     stream 7,8 with s_last on 8 -> err_len pulse; b and b_valid unchanged;
//     the next good frame commits normally.
//  3. Long frame:
//     6 words, s_last on the 6th -> err_len at word 5; words discarded until s_last; b unchanged.
//  4. Hold:
//     hold=1 before the frame ends, released 10 cycles later -> s_ready=0 during the wait;
//     commit on the first hold=0 cycle.
//  5. Backpressure and reset:
//     s_valid toggled randomly gives an identical result.
//     Reset pulse after word 3 -> all outputs 0; a fresh frame loads cleanly.
//  6. Checksum (macro on):
//     1,2,3,4,5 + 15 -> commit.
//     1,2,3,4,5 + 14 -> err_csum, no commit.
//     -1 x5 + 0xFFFB -> commit (wrap).

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared layer-pipeline word type and bias loader state encoding
// Also imported by the bias-add stage, so DATA_W changes here apply to both sides.
package nn_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] data_type;

    typedef enum logic [1:0] {
        LD_FILL   = 2'd0,
        LD_COMMIT = 2'd1,
        LD_DROP   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/bias_loader.sv
// rtl/bias_loader.sv - streams M bias words into a shadow buffer and commits them atomically to b
// Optional trailing checksum word per frame: define BIAS_LOADER_CHECKSUM_EN.
module bias_loader
    import nn_pkg::*;
#(
    parameter int M = 5
) (
    input  logic     clk,
    input  logic     reset,
    input  data_type s_data,
    input  logic     s_valid,
    input  logic     s_last,
    output logic     s_ready,
    input  logic     hold,
    output data_type b [0:M-1][0:0],
    output logic     b_valid,
    output logic     commit,
    output logic     err_len,
    output logic     err_csum
);

    localparam int                IDX_W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(M - 1);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             s_ready_q, s_ready_d;
    logic             b_valid_q, b_valid_d;
    logic             commit_q, commit_d;
    logic             err_len_q, err_len_d;
    logic             shadow_wr;
    logic             xfer;

    data_type shadow_q [M];
    data_type active_q [M];

`ifdef BIAS_LOADER_CHECKSUM_EN
    data_type sum_q, sum_d;
    logic     csum_phase_q, csum_phase_d;
    logic     err_csum_q, err_csum_d;
`endif

    assign xfer = s_valid && s_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LD_FILL;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            b_valid_q <= 1'b0;
            commit_q  <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= s_ready_d;
            b_valid_q <= b_valid_d;
            commit_q  <= commit_d;
            err_len_q <= err_len_d;
        end
    end

`ifdef BIAS_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q        <= '0;
            csum_phase_q <= 1'b0;
            err_csum_q   <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            csum_phase_q <= csum_phase_d;
            err_csum_q   <= err_csum_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_wr = 1'b0;
        commit_d  = 1'b0;
        err_len_d = 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        csum_phase_d = csum_phase_q;
        err_csum_d   = 1'b0;
`endif
        case (state_q)
            LD_FILL: begin
                if (xfer) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                    if (csum_phase_q) begin
                        // checksum word: the running sum already covers all M data words
                        csum_phase_d = 1'b0;
                        sum_d        = '0;
                        if (!s_last) begin
                            err_len_d = 1'b1;
                            state_d   = LD_DROP;
                        end else if (s_data == sum_q) begin
                            state_d = LD_COMMIT;
                        end else begin
                            err_csum_d = 1'b1;
                        end
                    end else begin
                        shadow_wr = 1'b1;
                        sum_d     = sum_q + s_data;
                        if (s_last) begin
                            err_len_d = 1'b1;
                            idx_d     = '0;
                            sum_d     = '0;
                        end else if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            csum_phase_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
`else
                    shadow_wr = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = LD_COMMIT;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = LD_DROP;
                        end
                    end else if (s_last) begin
                        err_len_d = 1'b1;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
`endif
                end
            end
            LD_COMMIT: begin
                // shadow stays intact while the datapath holds off the swap
                if (!hold) begin
                    commit_d = 1'b1;
                    idx_d    = '0;
                    state_d  = LD_FILL;
                end
            end
            LD_DROP: begin
                if (xfer && s_last) begin
                    idx_d   = '0;
                    state_d = LD_FILL;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = LD_FILL;
            end
        endcase
        s_ready_d = (state_d != LD_COMMIT);
        b_valid_d = b_valid_q || commit_d;
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end else begin
                if (shadow_wr && (idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= s_data;
                end
                if (commit_d) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
        assign b[i][0] = active_q[i];
    end

    assign s_ready = s_ready_q;
    assign b_valid = b_valid_q;
    assign commit  = commit_q;
    assign err_len = err_len_q;
`ifdef BIAS_LOADER_CHECKSUM_EN
    assign err_csum = err_csum_q;
`else
    assign err_csum = 1'b0;
`endif

endmodule

// File: tb/tb_bias_loader.sv
// tb/tb_bias_loader.sv - randomized self-checking bench for bias_loader against a frame-level model
module tb_bias_loader;
    import nn_pkg::*;

    localparam int M = 5;
`ifdef BIAS_LOADER_CHECKSUM_EN
    localparam int FRAME_LEN = M + 1;
`else
    localparam int FRAME_LEN = M;
`endif

    logic     clk     = 1'b0;
    logic     reset   = 1'b1;
    data_type s_data  = '0;
    logic     s_valid = 1'b0;
    logic     s_last  = 1'b0;
    logic     hold    = 1'b0;
    logic     s_ready, b_valid, commit, err_len, err_csum;
    data_type b [0:M-1][0:0];

    always #5 clk = ~clk;

    bias_loader #(.M(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .hold    (hold),
        .b       (b),
        .b_valid (b_valid),
        .commit  (commit),
        .err_len (err_len),
        .err_csum(err_csum)
    );

    int errors = 0;
    int checks = 0;

    // edge bookkeeping: after edge k, cyc == k
    int cyc = 0, xfer_edge = 0, commit_edge = -1, elen_edge = -1;
    int commit_cnt = 0, elen_cnt = 0, ecsum_cnt = 0;
    int last_xfer = 0;
    int xfer_at[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_valid && s_ready) xfer_edge <= cyc + 1;
        if (commit)   begin commit_cnt <= commit_cnt + 1; commit_edge <= cyc; end
        if (err_len)  begin elen_cnt <= elen_cnt + 1; elen_edge <= cyc; end
        if (err_csum) ecsum_cnt <= ecsum_cnt + 1;
    end

    // frame-level reference: a frame commits iff its length and checksum are right
    data_type model_b [M] = '{default: '0};
    bit       model_valid = 1'b0;
    int       exp_commit, exp_elen, exp_ecsum;

    task automatic model_frame(input data_type w[$]);
        exp_commit = 0; exp_elen = 0; exp_ecsum = 0;
`ifdef BIAS_LOADER_CHECKSUM_EN
        if (w.size() == M + 1) begin
            data_type s = '0;
            for (int i = 0; i < M; i++) s = data_type'(s + w[i]);
            if (s == w[M]) exp_commit = 1; else exp_ecsum = 1;
        end else begin
            exp_elen = 1;
        end
`else
        if (w.size() == M) exp_commit = 1; else exp_elen = 1;
`endif
        if (exp_commit == 1) begin
            for (int i = 0; i < M; i++) model_b[i] = w[i];
            model_valid = 1'b1;
        end
    endtask

    task automatic make_frame(input data_type p[$], output data_type w[$]);
        w = p;
`ifdef BIAS_LOADER_CHECKSUM_EN
        begin
            data_type s = '0;
            foreach (p[i]) s = data_type'(s + p[i]);
            w.push_back(s);
        end
`endif
    endtask

    task automatic rand_words(input int n, output data_type w[$]);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back(data_type'($urandom));
    endtask

    function automatic bit b_ok();
        for (int i = 0; i < M; i++) if (b[i][0] !== model_b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string b_str();
        string s = "b=";
        for (int i = 0; i < M; i++) s = {s, $sformatf("%0d ", b[i][0])};
        s = {s, "required="};
        for (int i = 0; i < M; i++) s = {s, $sformatf("%0d ", model_b[i])};
        return s;
    endfunction

    task automatic send_word(input data_type d, input logic last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (s_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end else begin
            s_data = d; s_last = last; s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0; s_last = 1'b0;
            last_xfer = xfer_edge;
            xfer_at.push_back(xfer_edge);
        end
    endtask

    task automatic send_frame(input data_type w[$], input int gap_max);
        xfer_at.delete();
        foreach (w[i]) send_word(w[i], (i == w.size() - 1), $urandom_range(gap_max, 0));
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || b_valid !== 1'b0 || commit !== 1'b0 || err_len !== 1'b0 || err_csum !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b commit=%b elen=%b ecsum=%b required all 0",
                     s_ready, b_valid, commit, err_len, err_csum);
        end
        checks++;
        if (!b_ok()) begin errors++; $display("FAIL reset_b: %s", b_str()); end
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: s_ready=%b required 0", s_ready); end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_basic();
        data_type p[$], w[$];
        int c0 = commit_cnt;
        for (int i = 1; i <= M; i++) p.push_back(data_type'(i));
        make_frame(p, w);
        model_frame(w);
        send_frame(w, 0);
        checks++;
        if (commit_cnt - c0 !== 1) begin errors++; $display("FAIL basic_commit: commits=%0d required 1", commit_cnt - c0); end
        checks++;
        if (commit_edge !== last_xfer + 1) begin
            errors++; $display("FAIL basic_latency: commit edge=%0d required %0d", commit_edge, last_xfer + 1);
        end
        checks++;
        if (!b_ok()) begin errors++; $display("FAIL basic_b: %s", b_str()); end
        checks++;
        if (b_valid !== 1'b1) begin errors++; $display("FAIL basic_b_valid: b_valid=%b required 1", b_valid); end
    endtask

    task automatic test_short_frame();
        data_type w[$], p[$];
        int c0 = commit_cnt, e0 = elen_cnt;
        w.push_back(data_type'(7));
        w.push_back(data_type'(8));
        model_frame(w);
        send_frame(w, 0);
        checks++;
        if (elen_cnt - e0 !== exp_elen) begin errors++; $display("FAIL short_err_len: pulses=%0d required %0d", elen_cnt - e0, exp_elen); end
        checks++;
        if (elen_edge !== last_xfer) begin errors++; $display("FAIL short_err_edge: edge=%0d required %0d", elen_edge, last_xfer); end
        checks++;
        if (commit_cnt - c0 !== 0 || !b_ok() || b_valid !== model_valid) begin
            errors++; $display("FAIL short_untouched: commits=%0d valid=%b required 0/%b %s", commit_cnt - c0, b_valid, model_valid, b_str());
        end
        rand_words(M, p);
        make_frame(p, w);
        model_frame(w);
        c0 = commit_cnt;
        send_frame(w, 0);
        checks++;
        if (commit_cnt - c0 !== 1 || !b_ok()) begin
            errors++; $display("FAIL short_recover: commits=%0d required 1 %s", commit_cnt - c0, b_str());
        end
    endtask

    task automatic test_long_frame();
        data_type w[$];
        int c0 = commit_cnt, e0 = elen_cnt;
        rand_words(FRAME_LEN + 1, w);
        model_frame(w);
        send_frame(w, 0);
        checks++;
        if (elen_cnt - e0 !== 1) begin errors++; $display("FAIL long_err_len: pulses=%0d required 1", elen_cnt - e0); end
        checks++;
        if (elen_edge !== xfer_at[FRAME_LEN-1]) begin
            errors++; $display("FAIL long_err_edge: edge=%0d required %0d", elen_edge, xfer_at[FRAME_LEN-1]);
        end
        checks++;
        if (commit_cnt - c0 !== 0 || !b_ok()) begin
            errors++; $display("FAIL long_untouched: commits=%0d required 0 %s", commit_cnt - c0, b_str());
        end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL long_ready: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_hold();
        data_type p[$], w[$];
        int c0 = commit_cnt;
        int rel;
        bit ready_bad = 1'b0, early = 1'b0;
        @(negedge clk);
        hold = 1'b1;
        rand_words(M, p);
        make_frame(p, w);
        model_frame(w);
        send_frame(w, 0);
        repeat (10) begin
            @(negedge clk);
            if (s_ready !== 1'b0) ready_bad = 1'b1;
            if (commit_cnt != c0) early = 1'b1;
        end
        checks++;
        if (ready_bad) begin errors++; $display("FAIL hold_ready: s_ready=%b during hold, required 0", s_ready); end
        checks++;
        if (early) begin errors++; $display("FAIL hold_early_commit: commits=%0d during hold, required 0", commit_cnt - c0); end
        hold = 1'b0;
        rel = cyc + 1;
        repeat (3) @(negedge clk);
        checks++;
        if (commit_cnt - c0 !== 1 || commit_edge !== rel) begin
            errors++; $display("FAIL hold_release: commits=%0d edge=%0d required 1 at %0d", commit_cnt - c0, commit_edge, rel);
        end
        checks++;
        if (!b_ok() || s_ready !== 1'b1) begin errors++; $display("FAIL hold_b: ready=%b required 1 %s", s_ready, b_str()); end
    endtask

    task automatic test_backpressure();
        data_type p[$], w[$];
        int c0, e0, s0;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                rand_words(M, p);
                make_frame(p, w);
            end else begin
                rand_words($urandom_range(FRAME_LEN + 2, 1), w);
            end
            model_frame(w);
            c0 = commit_cnt; e0 = elen_cnt; s0 = ecsum_cnt;
            send_frame(w, 3);
            checks++;
            if (commit_cnt - c0 !== exp_commit || elen_cnt - e0 !== exp_elen || ecsum_cnt - s0 !== exp_ecsum) begin
                errors++;
                $display("FAIL bp_pulses[%0d]: commit/elen/ecsum=%0d/%0d/%0d required %0d/%0d/%0d len=%0d", it,
                         commit_cnt - c0, elen_cnt - e0, ecsum_cnt - s0, exp_commit, exp_elen, exp_ecsum, w.size());
            end
            checks++;
            if (!b_ok() || b_valid !== model_valid) begin
                errors++; $display("FAIL bp_b[%0d]: valid=%b required %b %s", it, b_valid, model_valid, b_str());
            end
            if (exp_commit == 1) begin
                checks++;
                if (commit_edge !== last_xfer + 1) begin
                    errors++; $display("FAIL bp_latency[%0d]: edge=%0d required %0d", it, commit_edge, last_xfer + 1);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        data_type p[$], w[$];
        int c0;
        for (int i = 0; i < 3; i++) send_word(data_type'($urandom), 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < M; i++) model_b[i] = '0;
        model_valid = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0 || b_valid !== 1'b0 || commit !== 1'b0 || err_len !== 1'b0 || err_csum !== 1'b0 || !b_ok()) begin
            errors++; $display("FAIL mid_reset: ready=%b valid=%b commit=%b elen=%b required all 0 %s",
                               s_ready, b_valid, commit, err_len, b_str());
        end
        @(negedge clk);
        reset = 1'b0;
        rand_words(M, p);
        make_frame(p, w);
        model_frame(w);
        c0 = commit_cnt;
        send_frame(w, 2);
        checks++;
        if (commit_cnt - c0 !== 1 || !b_ok() || b_valid !== 1'b1) begin
            errors++; $display("FAIL mid_reset_reload: commits=%0d valid=%b required 1/1 %s", commit_cnt - c0, b_valid, b_str());
        end
    endtask

`ifdef BIAS_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        data_type w[$];
        int c0, s0;
        for (int t = 0; t < 3; t++) begin
            w.delete();
            for (int i = 1; i <= M; i++) w.push_back((t == 2) ? data_type'(-1) : data_type'(i));
            w.push_back((t == 0) ? data_type'(15) : (t == 1) ? data_type'(14) : data_type'(16'hFFFB));
            model_frame(w);
            c0 = commit_cnt; s0 = ecsum_cnt;
            send_frame(w, 0);
            checks++;
            if (commit_cnt - c0 !== ((t == 1) ? 0 : 1) || ecsum_cnt - s0 !== ((t == 1) ? 1 : 0)) begin
                errors++; $display("FAIL csum[%0d]: commit=%0d ecsum=%0d required %0d/%0d", t,
                                   commit_cnt - c0, ecsum_cnt - s0, (t == 1) ? 0 : 1, (t == 1) ? 1 : 0);
            end
            checks++;
            if (!b_ok()) begin errors++; $display("FAIL csum_b[%0d]: %s", t, b_str()); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_short_frame();
        test_long_frame();
        test_hold();
        test_backpressure();
        test_reset_midframe();
`ifdef BIAS_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
